dice_roller_bcd: RTL and testbench

Parametrised dice-roller core for the 32768 Hz TinyTapeout designs: debounces a bank of die-select buttons, spins a BCD counter modulo the selected die while a button is held, and latches the result on release. The result goes to a multi-digit time-multiplexed 7-segment display with leading-zero blanking. Compared with the current two-digit roller, it adds:

- a configurable digit count;
- true modulo wrap to the die maximum;
- per-die latching;
- a registered scan sequencer that does not depend on clock level.

---
 rtl/dice_roller_bcd_pkg.sv | 47 ++++
 rtl/dice_roller_bcd_if.sv | 32 +++
 rtl/dice_roller_bcd_debounce.sv | 44 ++++
 rtl/dice_roller_bcd.sv | 178 +++++++++++++++++
 tb/tb_dice_roller_bcd.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dice_roller_bcd_pkg.sv
// dice_pkg: shared types and constants for the dice roller.
//   DIE_MAX  : die maxima as 12-bit BCD (d4, d6, d8, d10, d12, d20, d100),
//              indexed by button number.
//   state_t  : roll controller states.
//   die_max  : safe table lookup (out-of-range index falls back to d4).
//   seg7     : BCD digit to {g..a} segment pattern, codes A-F blank.
package dice_pkg;

    localparam int NUM_DICE = 7;

    localparam logic [11:0] DIE_MAX [NUM_DICE] = '{
        12'h004, 12'h006, 12'h008, 12'h010, 12'h012, 12'h020, 12'h100
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ROLL = 1'b1
    } state_t;

    function automatic logic [11:0] die_max(input logic [2:0] sel);
        logic [11:0] v;
        v = DIE_MAX[0];
        for (int i = 0; i < NUM_DICE; i++) begin
            if (sel == 3'(i)) v = DIE_MAX[i];
        end
        return v;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dice_roller_bcd_if.sv
// Button / display bundle of the dice roller.
//   i_btn          raw die-select buttons, active high
//   i_seg_pol      1 = segments active high
//   i_com_pol      1 = commons active high
//   o_seg          {dp,g..a}, polarity applied
//   o_com          digit commons, bit 0 = units, polarity applied
//   o_result       latched BCD result
//   o_result_valid high while a released roll is shown
//   o_rolling      high while a die button is held
interface dice_roller_bcd_if #(
    parameter int NUM_DIGITS = 3,
    parameter int NUM_BTNS   = 7
);
    logic [NUM_BTNS-1:0]     i_btn;
    logic                    i_seg_pol;
    logic                    i_com_pol;
    logic [7:0]              o_seg;
    logic [NUM_DIGITS-1:0]   o_com;
    logic [4*NUM_DIGITS-1:0] o_result;
    logic                    o_result_valid;
    logic                    o_rolling;

    modport master (
        output i_btn, i_seg_pol, i_com_pol,
        input  o_seg, o_com, o_result, o_result_valid, o_rolling
    );

    modport slave (
        input  i_btn, i_seg_pol, i_com_pol,
        output o_seg, o_com, o_result, o_result_valid, o_rolling
    );
endinterface

// File: rtl/dice_roller_bcd_debounce.sv
// btn_debounce: 2-flop synchroniser plus agreement counter for one button.
//   clk, rst_n : clock, synchronous active-low reset
//   tick       : sample strobe from the shared prescaler
//   raw        : asynchronous button input
//   level      : debounced level, flips after DEB_SAMPLES consecutive
//                tick samples that disagree with it
module btn_debounce #(
    parameter int DEB_SAMPLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEB_SAMPLES + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], raw};
            if (tick) begin
                // Any sample agreeing with the current level restarts the run.
                if (r_sync[1] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(DEB_SAMPLES - 1)) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign level = r_level;
endmodule

// File: rtl/dice_roller_bcd.sv
// dice_roller_bcd: debounced die select, BCD spin counter, result latch
// and multiplexed 7-segment scan with leading-zero blanking.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : buttons, polarity controls and display/result outputs
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | showing last result, waiting for a rising edge of any button
// ST_ROLL | button held, counter spinning max..1 for the latched die
module dice_roller_bcd
    import dice_pkg::*;
#(
    parameter int NUM_DIGITS    = 3,
    parameter int NUM_BTNS      = 7,
    parameter int PRESCALE_BITS = 10,
    parameter int DEB_SAMPLES   = 3,
    parameter int SCAN_BITS     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dice_roller_bcd_if.slave  bus
);
    localparam int RW = 4 * NUM_DIGITS;

    logic [PRESCALE_BITS-1:0] r_presc;
    logic                     w_tick;
    logic [NUM_BTNS-1:0]      w_level;
    logic                     w_any;
    logic                     r_prev_any;
    logic [2:0]               w_low;

    state_t      r_state, w_state_nxt;
    logic        w_load, w_step, w_latch;
    logic [2:0]  r_die_sel;
    logic [11:0] r_cnt;
    logic [15:0] w_cnt16;
    logic [RW-1:0] r_result;
    logic        r_valid;

    logic [SCAN_BITS-1:0]  r_scan;
    logic [1:0]            r_idx;
    logic [RW-1:0]         w_upper;
    logic                  w_blank;
    logic [7:0]            w_seg_l;
    logic [NUM_DIGITS-1:0] w_com_l;
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_com;

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [11:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int d = 0; d < 3; d++) begin
            if (borrow) begin
                if (r[4*d +: 4] == 4'd0) begin
                    r[4*d +: 4] = 4'd9;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) r_presc <= '0;
        else        r_presc <= r_presc + PRESCALE_BITS'(1);
    end
    assign w_tick = (r_presc == '0);

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_deb
        btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (w_tick),
            .raw   (bus.i_btn[g]),
            .level (w_level[g])
        );
    end

    assign w_any = |w_level;

    always_comb begin
        w_low = 3'd0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (w_level[i]) w_low = 3'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && !r_prev_any) begin
                    w_state_nxt = ST_ROLL;
                    w_load      = 1'b1;
                end
            end
            ST_ROLL: begin
                if (w_any) begin
                    w_step = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_latch     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_cnt16 = {4'h0, r_cnt};

    // r_prev_any resets high so a level already high cannot look like an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_prev_any <= 1'b1;
            r_die_sel  <= 3'd0;
            r_cnt      <= 12'h001;
            r_result   <= RW'(1);
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev_any <= w_any;
            if (w_load) begin
                r_die_sel <= w_low;
                r_cnt     <= die_max(w_low);
                r_valid   <= 1'b0;
            end else if (w_step) begin
                r_cnt <= (r_cnt == 12'h001) ? die_max(r_die_sel) : bcd_dec(r_cnt);
            end
            if (w_latch) begin
                r_result <= w_cnt16[RW-1:0];
                r_valid  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_idx  <= 2'd0;
        end else begin
            r_scan <= r_scan + SCAN_BITS'(1);
            if (r_scan == '1) begin
                r_idx <= (r_idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : r_idx + 2'd1;
            end
        end
    end

    // A digit is blank when it and everything above it is zero (units never).
    assign w_upper = r_result >> {r_idx, 2'b00};
    assign w_blank = (r_idx != 2'd0) && (w_upper == '0);
    assign w_seg_l = w_blank ? 8'h00 : {1'b0, seg7(w_upper[3:0])};
    assign w_com_l = (w_blank || r_state == ST_ROLL) ? '0
                   : (NUM_DIGITS'(1) << r_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg <= {8{~bus.i_seg_pol}};
            r_com <= {NUM_DIGITS{~bus.i_com_pol}};
        end else begin
            r_seg <= w_seg_l ^ {8{~bus.i_seg_pol}};
            r_com <= w_com_l ^ {NUM_DIGITS{~bus.i_com_pol}};
        end
    end

    assign bus.o_seg          = r_seg;
    assign bus.o_com          = r_com;
    assign bus.o_result       = r_result;
    assign bus.o_result_valid = r_valid;
    assign bus.o_rolling      = (r_state == ST_ROLL);
endmodule

// File: tb/tb_dice_roller_bcd.sv
// Bench for dice_roller_bcd: randomized rolls against a behavioural model
// of the roll sequence, result formula and display scan.
module tb_dice_roller_bcd;
    localparam int ND = 3;
    localparam int NB = 7;
    localparam int PB = 5;
    localparam int DS = 3;
    localparam int SB = 4;
    localparam int TICK = 1 << PB;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dice_roller_bcd_if #(.NUM_DIGITS(ND), .NUM_BTNS(NB)) bus ();

    dice_roller_bcd #(
        .NUM_DIGITS(ND), .NUM_BTNS(NB), .PRESCALE_BITS(PB),
        .DEB_SAMPLES(DS), .SCAN_BITS(SB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int die_tab [7] = '{4, 6, 8, 10, 12, 20, 100};
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h00, 7'h00,
                                 7'h00, 7'h00, 7'h00, 7'h00};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return 12'((((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    function automatic int lowest(input logic [NB-1:0] m);
        int r;
        r = 0;
        for (int i = NB - 1; i >= 0; i--) if (m[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Roll model: values cycle max..1 one step per rolling cycle; the result
    // after L rolling cycles is ((max - L) mod max) + 1.
    int   m_die, m_max, m_exp, m_len;
    int   m_last_result = 1;
    logic m_roll_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            m_roll_prev = 1'b0;
        end else begin
            if (bus.o_rolling && !m_roll_prev) begin
                m_die = lowest(bus.i_btn);
                m_max = die_tab[m_die];
                m_exp = m_max;
                m_len = 1;
                check_eq("cnt_load", 32'(dut.r_cnt), 32'(to_bcd(m_exp)));
                check_eq("valid_drop", 32'(bus.o_result_valid), 32'(0));
            end else if (bus.o_rolling) begin
                m_exp = (m_exp == 1) ? m_max : m_exp - 1;
                m_len++;
                check_eq("cnt_step", 32'(dut.r_cnt), 32'(to_bcd(m_exp)));
            end else if (m_roll_prev) begin
                m_last_result = ((m_max - m_len) % m_max + m_max) % m_max + 1;
                check_eq("result", 32'(bus.o_result), 32'(to_bcd(m_last_result)));
                check_eq("result_valid", 32'(bus.o_result_valid), 32'(1));
            end
            m_roll_prev = bus.o_rolling;
        end
    end

    task automatic disp_check(input int cycles);
        logic [11:0]   r;
        logic [11:0]   up;
        logic [7:0]    es;
        logic [ND-1:0] ec;
        int            k;
        r = to_bcd(m_last_result);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            k  = ((cyc - 1) / (1 << SB)) % ND;
            up = r >> (4 * k);
            if (k > 0 && up == 12'h000) begin
                es = 8'h00;
                ec = '0;
            end else begin
                es = {1'b0, seg_tab[up[3:0]]};
                ec = ND'(1) << k;
            end
            if (!bus.i_seg_pol) es = ~es;
            if (!bus.i_com_pol) ec = ~ec;
            check_eq("seg", 32'(bus.o_seg), 32'(es));
            check_eq("com", 32'(bus.o_com), 32'(ec));
        end
    endtask

    task automatic wait_rolling(input logic lvl, input string tag);
        for (int i = 0; i < 800 && bus.o_rolling !== lvl; i++) @(negedge clk);
        check_eq(tag, 32'(bus.o_rolling), 32'(lvl));
    endtask

    task automatic roll(input logic [NB-1:0] mask, input int hold);
        bus.i_btn = mask;
        wait_rolling(1'b1, "roll_start");
        repeat (hold) @(negedge clk);
        bus.i_btn = '0;
        wait_rolling(1'b0, "roll_end");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic saw;
        int   lat;
        bus.i_btn     = '0;
        bus.i_seg_pol = 1'b1;
        bus.i_com_pol = 1'b1;
        rst_n         = 1'b0;

        repeat (5) @(negedge clk);
        check_eq("rst_result", 32'(bus.o_result), 32'h001);
        check_eq("rst_valid", 32'(bus.o_result_valid), 32'(0));
        check_eq("rst_rolling", 32'(bus.o_rolling), 32'(0));
        check_eq("rst_seg", 32'(bus.o_seg), 32'h00);
        check_eq("rst_com", 32'(bus.o_com), 32'(0));
        rst_n = 1'b1;
        disp_check(2 * ND * (1 << SB));

        // Bounce: the raw level flips every tick period so no run of
        // DS agreeing samples can form.
        saw = 1'b0;
        for (int t = 0; t < 96; t++) begin
            bus.i_btn[0] = (t % 2 == 0);
            repeat (TICK) begin
                @(negedge clk);
                if (bus.o_rolling) saw = 1'b1;
            end
        end
        check_eq("bounce_quiet", 32'(saw), 32'(0));
        bus.i_btn[0] = 1'b1;
        lat = 0;
        for (int i = 0; i < 400 && !bus.o_rolling; i++) begin
            @(negedge clk);
            lat++;
        end
        check_eq("deb_latency_in_window",
                 32'((lat >= (DS - 1) * TICK) && (lat <= (DS + 1) * TICK + 8)), 32'(1));
        repeat (50) @(negedge clk);
        bus.i_btn = '0;
        wait_rolling(1'b0, "bounce_end");
        repeat (3) @(negedge clk);

        for (int n = 0; n < 4; n++) roll(7'b0000010, $urandom_range(40, 300));
        disp_check(ND * (1 << SB));

        roll(7'b1000000, 260);
        bus.i_seg_pol = 1'($urandom_range(0, 1));
        bus.i_com_pol = 1'($urandom_range(0, 1));
        repeat (2) @(negedge clk);
        disp_check(2 * ND * (1 << SB));
        bus.i_seg_pol = 1'b1;
        bus.i_com_pol = 1'b1;

        bus.i_btn = 7'b0010100;
        wait_rolling(1'b1, "sim_start");
        check_eq("sim_die", 32'(dut.r_die_sel), 32'(2));
        repeat (20) @(negedge clk);
        bus.i_btn[5] = 1'b1;
        repeat (60) @(negedge clk);
        check_eq("sim_die_held", 32'(dut.r_die_sel), 32'(2));
        bus.i_btn = '0;
        wait_rolling(1'b0, "sim_end");
        repeat (3) @(negedge clk);

        for (int t = 0; t < 12 && m_last_result != 7; t++) roll(7'b0001000, 100 + TICK * t);
        check_eq("res_007", 32'(bus.o_result), 32'h007);
        bus.i_seg_pol = 1'b0;
        bus.i_com_pol = 1'b0;
        repeat (2) @(negedge clk);
        disp_check(3 * ND * (1 << SB));
        bus.i_seg_pol = 1'b1;
        bus.i_com_pol = 1'b1;

        for (int n = 0; n < 6; n++) begin
            roll(7'($urandom_range(1, 127)), $urandom_range(20, 400));
            repeat (2) @(negedge clk);
            disp_check(ND * (1 << SB));
        end

        bus.i_btn = 7'b0100000;
        wait_rolling(1'b1, "rst_roll_start");
        repeat (30) @(negedge clk);
        rst_n     = 1'b0;
        bus.i_btn = '0;
        repeat (2) @(negedge clk);
        check_eq("midrst_rolling", 32'(bus.o_rolling), 32'(0));
        check_eq("midrst_result", 32'(bus.o_result), 32'h001);
        check_eq("midrst_valid", 32'(bus.o_result_valid), 32'(0));
        check_eq("midrst_com", 32'(bus.o_com), 32'(0));
        rst_n = 1'b1;
        m_last_result = 1;
        repeat (3) @(negedge clk);
        disp_check(ND * (1 << SB));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
